// File: rtl/noc_request_axilite.sv
`default_nettype none
// ============================================================================
//  Module      : noc_request_axilite
//  Description : AXI4-Lite slave that turns buffered AR / AW+W requests into
//                OpenPiton non-cacheable load/store request packets.
//  Revision    : 1.0  initial release
// ============================================================================

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef NOC_CHIPID_WIDTH
`define NOC_CHIPID_WIDTH 14
`endif
`ifndef NOC_X_WIDTH
`define NOC_X_WIDTH 8
`endif
`ifndef NOC_Y_WIDTH
`define NOC_Y_WIDTH 8
`endif
`ifndef NOC_FBITS_WIDTH
`define NOC_FBITS_WIDTH 4
`endif
`ifndef PHY_ADDR_WIDTH
`define PHY_ADDR_WIDTH 40
`endif
`ifndef MSG_DST_CHIPID
`define MSG_DST_CHIPID 63:50
`define MSG_DST_X 49:42
`define MSG_DST_Y 41:34
`define MSG_DST_FBITS 33:30
`define MSG_LENGTH 29:22
`define MSG_TYPE 21:14
`define MSG_MSHRID 13:6
`define MSG_ADDR_ 55:16
`define MSG_SRC_CHIPID_ 63:50
`define MSG_SRC_X_ 49:42
`define MSG_SRC_Y_ 41:34
`define MSG_SRC_FBITS_ 33:30
`define MSG_DATA_SIZE_ 29:27
`endif
`ifndef MSG_TYPE_NC_LOAD_REQ
`define MSG_TYPE_NC_LOAD_REQ 8'd14
`define MSG_TYPE_NC_STORE_REQ 8'd15
`endif
`ifndef MSG_DATA_SIZE_64B
`define MSG_DATA_SIZE_8B 3'b100
`define MSG_DATA_SIZE_16B 3'b101
`define MSG_DATA_SIZE_32B 3'b110
`define MSG_DATA_SIZE_64B 3'b111
`endif

module noc_request_axilite #(
    parameter int AXI_LITE_ADDR_WIDTH = 64,
    parameter int AXI_LITE_DATA_WIDTH = 512,
    parameter int DATA_WORDS          = AXI_LITE_DATA_WIDTH / `NOC_DATA_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                               s_axi_arvalid,
    output logic                               s_axi_arready,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                               s_axi_awvalid,
    output logic                               s_axi_awready,
    input  logic [AXI_LITE_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [AXI_LITE_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                               s_axi_wvalid,
    output logic                               s_axi_wready,
    input  logic [`NOC_CHIPID_WIDTH-1:0]       src_chipid,
    input  logic [`NOC_X_WIDTH-1:0]            src_xpos,
    input  logic [`NOC_Y_WIDTH-1:0]            src_ypos,
    input  logic [`NOC_CHIPID_WIDTH-1:0]       dest_chipid,
    input  logic [`NOC_X_WIDTH-1:0]            dest_xpos,
    input  logic [`NOC_Y_WIDTH-1:0]            dest_ypos,
    input  logic [`NOC_FBITS_WIDTH-1:0]        dest_fbits,
    output logic                               noc_valid_out,
    output logic [`NOC_DATA_WIDTH-1:0]         noc_data_out,
    input  logic                               noc_ready_in
);

    localparam int c_noc_dw = `NOC_DATA_WIDTH;
    localparam int c_word_w = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam logic [c_word_w-1:0] c_last_word = c_word_w'(DATA_WORDS - 1);
    localparam logic [7:0] c_len_rd = 8'd2;
    localparam logic [7:0] c_len_wr = 8'(2 + DATA_WORDS);
    localparam logic [2:0] c_data_size =
        (AXI_LITE_DATA_WIDTH == 512) ? `MSG_DATA_SIZE_64B :
        (AXI_LITE_DATA_WIDTH == 256) ? `MSG_DATA_SIZE_32B :
        (AXI_LITE_DATA_WIDTH == 128) ? `MSG_DATA_SIZE_16B : `MSG_DATA_SIZE_8B;
    localparam logic c_grant_rd = 1'b0;
    localparam logic c_grant_wr = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_HDR2 = 3'd3,
        S_DATA = 3'd4
    } state_t;

    state_t                          r_state_q, w_state_d;
    logic                            r_grant_q, w_grant_d;
    logic                            r_last_grant_q;
    logic [c_word_w-1:0]             r_word_q, w_word_d;
    logic [7:0]                      r_tag_q;
    logic                            r_ar_v_q, r_aw_v_q, r_w_v_q;
    logic [`PHY_ADDR_WIDTH-1:0]      r_araddr_q, r_awaddr_q;
    logic [AXI_LITE_DATA_WIDTH-1:0]  r_wdata_q;
    logic                            r_valid_q;
    logic [c_noc_dw-1:0]             r_data_q;
    logic [c_noc_dw-1:0]             w_flit;
    logic                            w_hs, w_take, w_rd_release, w_wr_release;
    logic                            w_rd_pend, w_wr_pend;
    logic                            w_unused;
    logic [c_noc_dw-1:0]             w_words [DATA_WORDS];

    // Upper address bits and strobes carry no information for a full-width NC request.
    assign w_unused = ^{s_axi_araddr, s_axi_awaddr, s_axi_wstrb};

    assign s_axi_arready = !rst && !r_ar_v_q;
    assign s_axi_awready = !rst && !r_aw_v_q;
    assign s_axi_wready  = !rst && !r_w_v_q;

    assign noc_valid_out = r_valid_q;
    assign noc_data_out  = r_data_q;

    assign w_hs      = r_valid_q && noc_ready_in;
    assign w_rd_pend = r_ar_v_q;
    assign w_wr_pend = r_aw_v_q && r_w_v_q;

    for (genvar g = 0; g < DATA_WORDS; g++) begin : g_words
        assign w_words[g] = r_wdata_q[g*c_noc_dw +: c_noc_dw];
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_grant_d    = r_grant_q;
        w_word_d     = r_word_q;
        w_take       = 1'b0;
        w_rd_release = 1'b0;
        w_wr_release = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (w_rd_pend || w_wr_pend) begin
                    if (w_rd_pend && w_wr_pend) begin
                        w_grant_d = ~r_last_grant_q;
                    end else begin
                        w_grant_d = w_wr_pend ? c_grant_wr : c_grant_rd;
                    end
                    w_take    = 1'b1;
                    w_state_d = S_HDR0;
                end
            end
            S_HDR0: if (w_hs) w_state_d = S_HDR1;
            S_HDR1: if (w_hs) w_state_d = S_HDR2;
            S_HDR2: begin
                if (w_hs) begin
                    if (r_grant_q == c_grant_wr) begin
                        w_state_d = S_DATA;
                        w_word_d  = '0;
                    end else begin
                        w_state_d    = S_IDLE;
                        w_rd_release = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_hs) begin
                    if (r_word_q == c_last_word) begin
                        w_state_d    = S_IDLE;
                        w_wr_release = 1'b1;
                    end else begin
                        w_word_d = r_word_q + c_word_w'(1);
                    end
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    // Flit for the state being entered; it is registered so the NoC sees a stable output.
    always_comb begin
        w_flit = '0;
        case (w_state_d)
            S_HDR0: begin
                w_flit[`MSG_DST_CHIPID] = dest_chipid;
                w_flit[`MSG_DST_X]      = dest_xpos;
                w_flit[`MSG_DST_Y]      = dest_ypos;
                w_flit[`MSG_DST_FBITS]  = dest_fbits;
                w_flit[`MSG_LENGTH]     = (w_grant_d == c_grant_wr) ? c_len_wr : c_len_rd;
                w_flit[`MSG_TYPE]       = (w_grant_d == c_grant_wr) ? `MSG_TYPE_NC_STORE_REQ
                                                                    : `MSG_TYPE_NC_LOAD_REQ;
                w_flit[`MSG_MSHRID]     = r_tag_q;
            end
            S_HDR1: begin
                w_flit[`MSG_ADDR_] = (w_grant_d == c_grant_wr) ? r_awaddr_q : r_araddr_q;
            end
            S_HDR2: begin
                w_flit[`MSG_DATA_SIZE_]  = c_data_size;
                w_flit[`MSG_SRC_CHIPID_] = src_chipid;
                w_flit[`MSG_SRC_X_]      = src_xpos;
                w_flit[`MSG_SRC_Y_]      = src_ypos;
                w_flit[`MSG_SRC_FBITS_]  = '0;
            end
            S_DATA:  w_flit = w_words[w_word_d];
            default: w_flit = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= S_IDLE;
            r_grant_q      <= c_grant_rd;
            r_last_grant_q <= c_grant_wr;
            r_word_q       <= '0;
            r_tag_q        <= '0;
            r_ar_v_q       <= 1'b0;
            r_aw_v_q       <= 1'b0;
            r_w_v_q        <= 1'b0;
            r_araddr_q     <= '0;
            r_awaddr_q     <= '0;
            r_wdata_q      <= '0;
            r_valid_q      <= 1'b0;
            r_data_q       <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_grant_q <= w_grant_d;
            r_word_q  <= w_word_d;
            if (w_take) r_last_grant_q <= w_grant_d;
            if (r_state_q == S_HDR0 && w_hs) r_tag_q <= r_tag_q + 8'd1;

            if (s_axi_arvalid && s_axi_arready) begin
                r_ar_v_q   <= 1'b1;
                r_araddr_q <= s_axi_araddr[`PHY_ADDR_WIDTH-1:0];
            end else if (w_rd_release) begin
                r_ar_v_q <= 1'b0;
            end
            if (s_axi_awvalid && s_axi_awready) begin
                r_aw_v_q   <= 1'b1;
                r_awaddr_q <= s_axi_awaddr[`PHY_ADDR_WIDTH-1:0];
            end else if (w_wr_release) begin
                r_aw_v_q <= 1'b0;
            end
            if (s_axi_wvalid && s_axi_wready) begin
                r_w_v_q   <= 1'b1;
                r_wdata_q <= s_axi_wdata;
            end else if (w_wr_release) begin
                r_w_v_q <= 1'b0;
            end

            if (!r_valid_q || noc_ready_in) begin
                r_valid_q <= (w_state_d != S_IDLE);
                r_data_q  <= w_flit;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/noc_request_axilite.md
Name: noc_request_axilite

Overview:
- AXI4-Lite slave that turns accelerator read and write requests into OpenPiton non-cacheable memory request packets on a single NoC output.
- Counterpart of the response path, which converts NC load/store memory ACKs back into AXI R/B.
- Sits between the accelerator's AXI-Lite master port and the chipset NoC toward the memory splitter.
- One AR, one AW and one W holding buffer; reads and writes are arbitrated round-robin onto the NoC.

Parameters:
- AXI_LITE_ADDR_WIDTH, 64, AXI address width; only the low `PHY_ADDR_WIDTH bits are forwarded.
- AXI_LITE_DATA_WIDTH, 512, AXI data width. Must be a multiple of `NOC_DATA_WIDTH and at most 512.
- DATA_WORDS, AXI_LITE_DATA_WIDTH/`NOC_DATA_WIDTH, store payload flit count. Derived parameter; do not override.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_axi_araddr  in  AXI_LITE_ADDR_WIDTH  read address
- s_axi_arvalid  in  1  AR valid
- s_axi_arready  out  1  AR ready
- s_axi_awaddr  in  AXI_LITE_ADDR_WIDTH  write address
- s_axi_awvalid  in  1  AW valid
- s_axi_awready  out  1  AW ready
- s_axi_wdata  in  AXI_LITE_DATA_WIDTH  write data
- s_axi_wstrb  in  AXI_LITE_DATA_WIDTH/8  write strobe; ignored, every store is full width
- s_axi_wvalid  in  1  W valid
- s_axi_wready  out  1  W ready
- src_chipid  in  `NOC_CHIPID_WIDTH  source chip id
- src_xpos  in  `NOC_X_WIDTH  source X position
- src_ypos  in  `NOC_Y_WIDTH  source Y position
- dest_chipid  in  `NOC_CHIPID_WIDTH  destination chip id
- dest_xpos  in  `NOC_X_WIDTH  destination X position
- dest_ypos  in  `NOC_Y_WIDTH  destination Y position
- dest_fbits  in  `NOC_FBITS_WIDTH  destination final bits
- noc_valid_out  out  1  flit valid
- noc_data_out  out  `NOC_DATA_WIDTH  flit
- noc_ready_in  in  1  downstream ready

Behaviour:
- Single clock `clk`; synchronous active-high reset `rst`.
- Reset state:
  - All buffers invalid, FSM in IDLE, tag counter 0.
  - last_grant = WRITE, so the first tie goes to read.
  - noc_valid_out = 0 and noc_data_out = 0 (both registered).
- Ready signals:
  - arready = !rst && !ar_v; awready = !rst && !aw_v; wready = !rst && !w_v.
  - A handshake in cycle N sets the buffer valid from N+1.
  - A buffer cannot be accepted into and released in the same cycle; ready rises the cycle after release.
- AW and W are buffered independently and may arrive in either order or together. A write is pending only when aw_v && w_v.
- FSM states: IDLE, HDR0, HDR1, HDR2, DATA.
- IDLE arbitration:
  - rd = ar_v; wr = aw_v && w_v.
  - If only one is set, grant it. If both are set, grant the opposite of last_grant.
  - On grant: latch the grant, update last_grant and go to HDR0. noc_valid_out rises the next cycle.
  - Minimum latency: AR handshake at N → header0 valid at N+2.
- Flit progression:
  - Each state holds noc_valid_out = 1 with stable noc_data_out until noc_valid_out && noc_ready_in.
  - Order: HDR0 → HDR1 → HDR2; then IDLE for a read, or DATA for a write.
- Header0 contents (all unlisted bits 0):
  - `MSG_DST_CHIPID/X/Y/FBITS = dest_* ports.
  - `MSG_LENGTH = 2 for a read, 2+DATA_WORDS for a write.
  - `MSG_TYPE = `MSG_TYPE_NC_LOAD_REQ or `MSG_TYPE_NC_STORE_REQ.
  - `MSG_MSHRID = tag.
- Header1: `MSG_ADDR_ = buffered address[`PHY_ADDR_WIDTH-1:0].
- Header2:
  - `MSG_DATA_SIZE_ = the size code for AXI_LITE_DATA_WIDTH/8 bytes (64B → `MSG_DATA_SIZE_64B).
  - `MSG_SRC_CHIPID_/X_/Y_ = src_* ports; `MSG_SRC_FBITS_ = 0.
- Tag: 8-bit counter, increments on each header0 handshake, wraps 255→0.
- DATA state:
  - Word counter k runs 0..DATA_WORDS-1; flit k = wdata_buf[k*`NOC_DATA_WIDTH +: `NOC_DATA_WIDTH], word 0 first.
  - On handshake of word DATA_WORDS-1, go to IDLE.
- Buffer release:
  - ar_v clears on the HDR2 handshake of a read.
  - aw_v and w_v clear together on the last DATA handshake.
  - Back-to-back packets: IDLE costs one bubble cycle.
- noc_ready_in low: hold state, data and tag. No flit is dropped or duplicated.
- Reset mid-packet: the packet is abandoned, noc_valid_out = 0 the next cycle, buffers are cleared and tag returns to 0.
- Inputs captured in buffers are never re-sampled during a packet.

Test Plan:
- Single read:
  - Stimulus: AR addr 0x0000_8000_0040, noc_ready_in = 1.
  - Response: 3 flits in cycles N+2..N+4, LENGTH = 2, TYPE = NC_LOAD_REQ, MSHRID = 0, header1 addr 0x8000_0040; arready high again at N+5.
- Single 512-bit write:
  - Stimulus: W arrives 3 cycles before AW.
  - Response: 11 flits, LENGTH = 10, data flits equal wdata[63:0] … wdata[511:448] in order; awready and wready reassert after the last flit.
- Simultaneous AR and complete write pending in IDLE after reset:
  - Response: read packet first, then write. Next tie grants write.
- Backpressure:
  - Stimulus: noc_ready_in toggled pseudo-randomly during a write.
  - Response: each flit is held stable while ready is low; the flit sequence is identical to the no-stall case.
- Tag wrap:
  - Stimulus: 257 consecutive reads.
  - Response: MSHRIDs 0..255, then 0.
- Reset asserted during a DATA flit:
  - Response: noc_valid_out = 0 next cycle, ready signals 0 during reset and 1 after; the subsequent read carries MSHRID 0.
